// File: rtl/cps_pkg.sv
// Shared types and widths for the parking-controller keypad front end.
//   DIGIT_W     : width of one keypad digit
//   PW_W        : width of the assembled garage password (two digits)
//   cps_state_e : state of the password-entry FSM
package cps_pkg;

  localparam int DIGIT_W = 4;
  localparam int PW_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    DIGIT_HI,
    DIGIT_LO,
    PRESENT,
    WAIT_RESULT,
    GRANTED,
    LOCKOUT
  } cps_state_e;

endpackage

// File: rtl/cps_down_counter.sv
// Loadable down counter with a zero flag. Stops at zero instead of wrapping.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one while non-zero
//   zero     : count is zero
module cps_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cps_password_entry.sv
// Keypad-side front end for the car parking controller. Detects an arriving
// car, assembles two keypad digits into the garage password, presents it to
// the controller, interprets the green/red reply and enforces a lockout after
// MAX_ATTEMPTS failures (red reply or no reply within RESULT_TIMEOUT cycles).
//   clk, rst         : clock; synchronous active-high reset
//   car_present      : entrance detector level
//   key_valid        : one-cycle strobe qualifying key_digit
//   key_digit        : pressed digit
//   green_led        : controller grant
//   red_led          : controller deny
//   sensor_entrance  : to controller, high in every state except IDLE/LOCKOUT
//   garage_password  : to controller, assembled password
//   pw_valid         : one-cycle pulse when a new password is presented
//   granted          : one-cycle pulse on grant
//   locked           : high throughout LOCKOUT
//   attempt_cnt      : failed attempts so far, saturating at MAX_ATTEMPTS
module cps_password_entry
  import cps_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int RESULT_TIMEOUT = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              car_present,
  input  logic                              key_valid,
  input  logic [DIGIT_W-1:0]                key_digit,
  input  logic                              green_led,
  input  logic                              red_led,
  output logic                              sensor_entrance,
  output logic [PW_W-1:0]                   garage_password,
  output logic                              pw_valid,
  output logic                              granted,
  output logic                              locked,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempt_cnt
);

  localparam int CNT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int TO_W  = $clog2(RESULT_TIMEOUT + 1);
  localparam int LO_W  = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ATTEMPTS);
  // Timers are loaded one below their length: the zero flag is then seen on
  // the edge that closes the last cycle of the wait, which is where the
  // timeout failure or lockout exit must register.
  localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(RESULT_TIMEOUT - 1);
  localparam logic [LO_W-1:0]  LO_LOAD = LO_W'(LOCKOUT_CYCLES - 1);

  cps_state_e       state;
  logic             to_zero;
  logic             lo_zero;
  logic [CNT_W-1:0] att_next;

  // Both timers sit preloaded outside the state they time, and count only
  // inside it.
  cps_down_counter #(.W(TO_W)) u_result_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state != WAIT_RESULT),
    .load_val (TO_LOAD),
    .dec      (state == WAIT_RESULT),
    .zero     (to_zero)
  );

  cps_down_counter #(.W(LO_W)) u_lockout_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state != LOCKOUT),
    .load_val (LO_LOAD),
    .dec      (state == LOCKOUT),
    .zero     (lo_zero)
  );

  assign att_next = (attempt_cnt == MAX_CNT) ? attempt_cnt : attempt_cnt + 1'b1;

  // Outputs are registered and updated on the edge that enters the state
  // they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sensor_entrance <= 1'b0;
      garage_password <= '0;
      pw_valid        <= 1'b0;
      granted         <= 1'b0;
      locked          <= 1'b0;
      attempt_cnt     <= '0;
    end else begin
      pw_valid <= 1'b0;
      granted  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (car_present) begin
            state           <= DIGIT_HI;
            sensor_entrance <= 1'b1;
          end
        end

        DIGIT_HI: begin
          if (!car_present) begin
            state           <= IDLE;
            sensor_entrance <= 1'b0;
            garage_password <= '0;
          end else if (key_valid) begin
            garage_password[PW_W-1 -: DIGIT_W] <= key_digit;
            state                              <= DIGIT_LO;
          end
        end

        DIGIT_LO: begin
          if (!car_present) begin
            state           <= IDLE;
            sensor_entrance <= 1'b0;
            garage_password <= '0;
          end else if (key_valid) begin
            garage_password[DIGIT_W-1:0] <= key_digit;
            pw_valid                     <= 1'b1;
            state                        <= PRESENT;
          end
        end

        PRESENT: begin
          if (!car_present) begin
            state           <= IDLE;
            sensor_entrance <= 1'b0;
            garage_password <= '0;
          end else begin
            state <= WAIT_RESULT;
          end
        end

        WAIT_RESULT: begin
          if (!car_present) begin
            state           <= IDLE;
            sensor_entrance <= 1'b0;
            garage_password <= '0;
          end else if (green_led) begin
            state       <= GRANTED;
            granted     <= 1'b1;
            attempt_cnt <= '0;
          end else if (red_led || to_zero) begin
            attempt_cnt <= att_next;
            if (att_next == MAX_CNT) begin
              state           <= LOCKOUT;
              locked          <= 1'b1;
              sensor_entrance <= 1'b0;
            end else begin
              state <= DIGIT_HI;
            end
          end
        end

        GRANTED: begin
          if (!car_present) begin
            state           <= IDLE;
            sensor_entrance <= 1'b0;
            garage_password <= '0;
          end
        end

        LOCKOUT: begin
          if (lo_zero) begin
            state           <= IDLE;
            locked          <= 1'b0;
            attempt_cnt     <= '0;
            garage_password <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cps_password_entry.sv
// Self-checking bench for cps_password_entry: reset check, a table of
// directed vectors, hand-written lockout/timeout/reset sequences, and a
// randomized run compared every cycle against a behavioural model.
module tb_cps_password_entry;

  localparam int MAX_ATT = 3;
  localparam int LOCK_N  = 16;
  localparam int TO_N    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       car_present;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       green_led;
  logic       red_led;
  logic       sensor_entrance;
  logic [7:0] garage_password;
  logic       pw_valid;
  logic       granted;
  logic       locked;
  logic [1:0] attempt_cnt;

  cps_password_entry #(
    .MAX_ATTEMPTS   (MAX_ATT),
    .LOCKOUT_CYCLES (LOCK_N),
    .RESULT_TIMEOUT (TO_N)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .car_present     (car_present),
    .key_valid       (key_valid),
    .key_digit       (key_digit),
    .green_led       (green_led),
    .red_led         (red_led),
    .sensor_entrance (sensor_entrance),
    .garage_password (garage_password),
    .pw_valid        (pw_valid),
    .granted         (granted),
    .locked          (locked),
    .attempt_cnt     (attempt_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural reference model ----------------
  // A session is "open" while the car is being served; digits are collected
  // with a count of nibbles taken; the reply wait and lockout are tracked as
  // elapsed/remaining cycle counts.
  bit m_sess, m_pres, m_wait, m_hold, m_pwv, m_gr;
  int m_ndig, m_elapsed, m_lock_left, m_fails, m_pw;

  task automatic m_close();
    m_sess = 0; m_pres = 0; m_wait = 0; m_hold = 0; m_ndig = 0; m_pw = 0;
  endtask

  task automatic model_edge();
    m_pwv = 0;
    m_gr  = 0;
    if (rst) begin
      m_close();
      m_lock_left = 0;
      m_fails     = 0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) begin
        m_fails = 0;
        m_pw    = 0;
      end
    end else if (!m_sess) begin
      if (car_present) begin
        m_sess = 1;
        m_ndig = 0;
      end
    end else if (!car_present) begin
      m_close();
    end else if (m_hold) begin
      // waiting for the car to leave
    end else if (m_pres) begin
      m_pres    = 0;
      m_wait    = 1;
      m_elapsed = 0;
    end else if (m_wait) begin
      m_elapsed++;
      if (green_led) begin
        m_wait  = 0;
        m_hold  = 1;
        m_gr    = 1;
        m_fails = 0;
      end else if (red_led || m_elapsed == TO_N) begin
        m_wait  = 0;
        m_fails = (m_fails + 1 > MAX_ATT) ? MAX_ATT : m_fails + 1;
        m_ndig  = 0;
        if (m_fails == MAX_ATT) begin
          m_sess      = 0;
          m_lock_left = LOCK_N;
        end
      end
    end else if (key_valid) begin
      if (m_ndig == 0) begin
        m_pw   = int'(key_digit) * 16 + m_pw % 16;
        m_ndig = 1;
      end else begin
        m_pw   = (m_pw / 16) * 16 + int'(key_digit);
        m_ndig = 0;
        m_pres = 1;
        m_pwv  = 1;
      end
    end
  endtask

  function automatic logic [13:0] model_out();
    return {m_sess, m_pw[7:0], m_pwv, m_gr, (m_lock_left > 0), m_fails[1:0]};
  endfunction

  function automatic logic [13:0] dut_out();
    return {sensor_entrance, garage_password, pw_valid, granted, locked, attempt_cnt};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int car, input int kv, input int kd, input int g, input int r);
    car_present = (car != 0);
    key_valid   = (kv != 0);
    key_digit   = 4'(kd);
    green_led   = (g != 0);
    red_led     = (r != 0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // From DIGIT_HI: enter 0x12 and receive a red reply.
  task automatic attempt_red();
    drive(1, 1, 1, 0, 0); step();
    drive(1, 1, 2, 0, 0); step();
    drive(1, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 1); step();
    drive(1, 0, 0, 0, 0);
  endtask

  typedef struct packed {
    logic        car;
    logic        kv;
    logic [3:0]  kd;
    logic        g;
    logic        r;
    logic [13:0] exp;  // {sensor, password, pw_valid, granted, locked, attempt_cnt}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input int car, input int kv, input int kd, input int g, input int r,
                             input int sens, input int pw, input int pwv, input int gr,
                             input int lk, input int att);
    vec_t x;
    x.car = (car != 0);
    x.kv  = (kv != 0);
    x.kd  = 4'(kd);
    x.g   = (g != 0);
    x.r   = (r != 0);
    x.exp = {(sens != 0), 8'(pw), (pwv != 0), (gr != 0), (lk != 0), 2'(att)};
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lk_cycles;
    int k_hit;
    bit stray;

    m_close();
    m_lock_left = 0;
    m_fails     = 0;

    // -------- reset --------
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    step(); step();
    check("reset_state", 32'(dut_out()), 32'(0));
    rst = 1'b0;

    // -------- directed vector table --------
    //          car kv kd  g  r  | sens pw  pwv gr lk att
    // happy path
    vecs.push_back(v(0, 0, 0,  0, 0,   0, 'h00, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,  0, 0,   1, 'h00, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 13, 0, 0,   1, 'hD0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,  0, 0,   1, 'hD0, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 5,  0, 0,   1, 'hD5, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 6,  0, 0,   1, 'hD5, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 7,  0, 0,   1, 'hD5, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,  1, 0,   1, 'hD5, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0,  0, 0,   1, 'hD5, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,  0, 0,   0, 'h00, 0, 0, 0, 0));
    // retry after red
    vecs.push_back(v(1, 0, 0,  0, 0,   1, 'h00, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 1,  0, 0,   1, 'h10, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 2,  0, 0,   1, 'h12, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,  0, 0,   1, 'h12, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,  0, 1,   1, 'h12, 0, 0, 0, 1));
    vecs.push_back(v(1, 1, 14, 0, 0,   1, 'hE2, 0, 0, 0, 1));
    vecs.push_back(v(1, 1, 15, 0, 0,   1, 'hEF, 1, 0, 0, 1));
    vecs.push_back(v(1, 0, 0,  0, 0,   1, 'hEF, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0,  1, 0,   1, 'hEF, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0,  0, 0,   0, 'h00, 0, 0, 0, 0));
    // green and red together: green wins
    vecs.push_back(v(1, 0, 0,  0, 0,   1, 'h00, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 3,  0, 0,   1, 'h30, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 4,  0, 0,   1, 'h34, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,  0, 0,   1, 'h34, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,  0, 1,   1, 'h34, 0, 0, 0, 1));
    vecs.push_back(v(1, 1, 3,  0, 0,   1, 'h34, 0, 0, 0, 1));
    vecs.push_back(v(1, 1, 4,  0, 0,   1, 'h34, 1, 0, 0, 1));
    vecs.push_back(v(1, 0, 0,  0, 0,   1, 'h34, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0,  1, 1,   1, 'h34, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0,  0, 0,   0, 'h00, 0, 0, 0, 0));
    // car backs out mid-entry: password cleared, failures kept
    vecs.push_back(v(1, 0, 0,  0, 0,   1, 'h00, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 10, 0, 0,   1, 'hA0, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 11, 0, 0,   1, 'hAB, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,  0, 0,   1, 'hAB, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,  0, 1,   1, 'hAB, 0, 0, 0, 1));
    vecs.push_back(v(1, 1, 9,  0, 0,   1, 'h9B, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,  0, 0,   0, 'h00, 0, 0, 0, 1));
    // key on the edge that enters DIGIT_HI is ignored
    vecs.push_back(v(1, 1, 7,  0, 0,   1, 'h00, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0,  0, 0,   1, 'h00, 0, 0, 0, 1));
    vecs.push_back(v(1, 1, 12, 0, 0,   1, 'hC0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,  0, 0,   0, 'h00, 0, 0, 0, 1));

    foreach (vecs[i]) begin
      drive(int'(vecs[i].car), int'(vecs[i].kv), int'(vecs[i].kd),
            int'(vecs[i].g), int'(vecs[i].r));
      step();
      check($sformatf("vec[%0d]", i), 32'(dut_out()), 32'(vecs[i].exp));
    end

    // -------- lockout after three reds --------
    rst = 1'b1;
    drive(1, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    attempt_red();
    attempt_red();
    attempt_red();
    check("lockout_entry", 32'({locked, sensor_entrance, attempt_cnt}), 32'({1'b1, 1'b0, 2'd3}));
    lk_cycles = 1;
    stray     = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1, 1, int'($urandom_range(0, 15)), 0, 0);
      step();
      if (!locked) break;
      lk_cycles++;
      if (pw_valid || sensor_entrance) stray = 1;
    end
    check("lockout_len", lk_cycles, LOCK_N);
    check("lockout_keys_ignored", 32'(stray), 32'(0));
    check("lockout_exit", 32'({sensor_entrance, garage_password, attempt_cnt}), 32'(0));
    drive(1, 0, 0, 0, 0);
    step();
    check("reenter_digit_hi", 32'(sensor_entrance), 32'(1));

    // -------- reply timeout --------
    drive(1, 1, 6, 0, 0); step();
    drive(1, 1, 9, 0, 0); step();
    check("timeout_pw", 32'({garage_password, pw_valid}), 32'({8'h69, 1'b1}));
    drive(1, 0, 0, 0, 0); step();
    k_hit = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (attempt_cnt != 2'd0) begin
        k_hit = k;
        break;
      end
    end
    check("timeout_cycles", k_hit, TO_N);
    check("timeout_cnt", 32'({sensor_entrance, attempt_cnt}), 32'({1'b1, 2'd1}));

    // -------- reset during lockout --------
    attempt_red();
    attempt_red();
    check("lockout2_entry", 32'(locked), 32'(1));
    step(); step(); step();
    rst = 1'b1;
    step();
    check("reset_in_lockout", 32'(dut_out()), 32'(0));
    rst = 1'b0;
    step();
    check("post_reset_entry", 32'({sensor_entrance, locked}), 32'({1'b1, 1'b0}));
    drive(1, 1, 2, 0, 0); step();
    drive(1, 1, 8, 0, 0); step();
    check("post_reset_pw", 32'({garage_password, pw_valid}), 32'({8'h28, 1'b1}));

    // -------- randomized run against the model --------
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      drive(int'($urandom_range(0, 19) != 0), int'($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 7) == 0));
      step();
      check($sformatf("rand[%0d]", c), 32'(dut_out()), 32'(model_out()));
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
